// File: rtl/parity_check_fsm.sv
// Serial parity checker: shifts in an LSB-first frame and a parity bit, then reports the word and the check result.
// Optional saturating parity-error counter is built when PARITY_CHECK_ERRCNT_EN is defined.
module parity_check_fsm #(
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 start,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    // A one-bit frame has no DATA phase: bit 0 is also the last data bit.
    localparam logic [1:0] FIRST_NEXT = (DATA_BITS == 1) ? PARITY : DATA;

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic                 par;
    logic [DATA_BITS-1:0] shreg;
    logic                 restart;
    logic                 frame_err;

    assign restart   = din_valid & start;
    assign frame_err = par ^ din ^ ODD_PARITY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            par         <= 1'b0;
            shreg       <= '0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
`ifdef PARITY_CHECK_ERRCNT_EN
            err_count   <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            if (restart) begin
                // A start always begins a new frame; any frame in flight is dropped.
                frame_abort <= (state != IDLE);
                shreg       <= '0;
                shreg[0]    <= din;
                par         <= din;
                cnt         <= CW'(1);
                state       <= FIRST_NEXT;
                busy        <= 1'b1;
            end else if (din_valid) begin
                case (state)
                    DATA: begin
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (CW'(i) == cnt) shreg[i] <= din;
                        end
                        par <= par ^ din;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        frame_valid <= 1'b1;
                        parity_err  <= frame_err;
                        data_out    <= shreg;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        cnt         <= '0;
                        par         <= 1'b0;
`ifdef PARITY_CHECK_ERRCNT_EN
                        if (frame_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef PARITY_CHECK_ERRCNT_EN
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_check_fsm.sv
// Directed self-checking bench for parity_check_fsm (even-parity DUT plus an odd-parity DUT on shared stimulus).
module tb_parity_check_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       start = 1'b0;

    logic [7:0] data_out, o_data_out;
    logic       frame_valid, o_frame_valid;
    logic       parity_err, o_parity_err;
    logic       frame_abort, o_frame_abort;
    logic       busy, o_busy;
    logic [7:0] err_count, o_err_count;

    int errors = 0;
    int checks = 0;
    int fv_seen = 0;
    int ab_seen = 0;
    int overlap = 0;
    int exp_ec = 0;

    parity_check_fsm #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start),
        .data_out(data_out), .frame_valid(frame_valid), .parity_err(parity_err),
        .frame_abort(frame_abort), .busy(busy), .err_count(err_count)
    );

    parity_check_fsm #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start),
        .data_out(o_data_out), .frame_valid(o_frame_valid), .parity_err(o_parity_err),
        .frame_abort(o_frame_abort), .busy(o_busy), .err_count(o_err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_seen++;
        if (frame_abort === 1'b1) ab_seen++;
        if (frame_valid === 1'b1 && frame_abort === 1'b1) overlap++;
    end

    // One valid beat, sampled at the next rising edge; outputs are read 1 ns later.
    task automatic send_bit(input logic d, input logic s);
        din = d; din_valid = 1'b1; start = s;
        @(posedge clk); #1;
        din_valid = 1'b0; start = 1'b0; din = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic bump_ec(input logic bad);
`ifdef PARITY_CHECK_ERRCNT_EN
        if (bad && exp_ec < 255) exp_ec++;
`else
        if (bad) exp_ec = 0;
`endif
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_frame_abort got=%b exp=0", frame_abort); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_even_ok;
        int fv0;
        fv0 = fv_seen;
        send_data(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL even_ok_busy got=%b exp=1", busy); end
        checks++; if (fv_seen != fv0) begin errors++; $display("FAIL even_ok_early_fv got=%0d exp=%0d", fv_seen, fv0); end
        send_bit(1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL even_ok_fv got=%b exp=1", frame_valid); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL even_ok_data got=%h exp=a5", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL even_ok_perr got=%b exp=0", parity_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL even_ok_busy_after got=%b exp=0", busy); end
        idle(1);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL even_ok_fv_pulse got=%b exp=0", frame_valid); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL even_ok_data_hold got=%h exp=a5", data_out); end
    endtask

    task automatic test_even_bad;
        send_data(8'hA5);
        send_bit(1'b1, 1'b0);
        bump_ec(1'b1);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL even_bad_fv got=%b exp=1", frame_valid); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL even_bad_perr got=%b exp=1", parity_err); end
        checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL even_bad_err_count got=%0d exp=%0d", err_count, exp_ec); end
        idle(2);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL even_bad_perr_hold got=%b exp=1", parity_err); end
    endtask

    task automatic test_odd;
        send_data(8'h01);
        send_bit(1'b0, 1'b0);
        bump_ec(1'b0);
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL odd_01_fv got=%b exp=1", o_frame_valid); end
        checks++; if (o_parity_err !== 1'b0) begin errors++; $display("FAIL odd_01_perr got=%b exp=0", o_parity_err); end
        checks++; if (o_data_out !== 8'h01) begin errors++; $display("FAIL odd_01_data got=%h exp=01", o_data_out); end
        send_data(8'h03);
        send_bit(1'b0, 1'b0);
        bump_ec(1'b0);
        checks++; if (o_parity_err !== 1'b1) begin errors++; $display("FAIL odd_03_perr got=%b exp=1", o_parity_err); end
        checks++; if (o_data_out !== 8'h03) begin errors++; $display("FAIL odd_03_data got=%h exp=03", o_data_out); end
        idle(1);
    endtask

    task automatic test_gaps;
        int fv0;
        logic [7:0] d;
        d = 8'h3C;
        fv0 = fv_seen;
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], i == 0);
            idle(i % 4);
        end
        checks++; if (fv_seen != fv0) begin errors++; $display("FAIL gaps_spurious_fv got=%0d exp=%0d", fv_seen, fv0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy got=%b exp=1", busy); end
        idle(3);
        send_bit(1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL gaps_fv got=%b exp=1", frame_valid); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL gaps_data got=%h exp=3c", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL gaps_perr got=%b exp=0", parity_err); end
        idle(1);
    endtask

    task automatic test_abort;
        int fv0, ab0;
        logic [7:0] d;
        d = 8'h0F;
        fv0 = fv_seen; ab0 = ab_seen;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(d[0], 1'b1);
        checks++; if (frame_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%b exp=1", frame_abort); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got=%b exp=1", busy); end
        for (int i = 1; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL abort_fv got=%b exp=1", frame_valid); end
        checks++; if (data_out !== 8'h0F) begin errors++; $display("FAIL abort_data got=%h exp=0f", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL abort_perr got=%b exp=0", parity_err); end
        idle(1);
        checks++; if (ab_seen - ab0 != 1) begin errors++; $display("FAIL abort_count got=%0d exp=1", ab_seen - ab0); end
        checks++; if (fv_seen - fv0 != 1) begin errors++; $display("FAIL abort_fv_count got=%0d exp=1", fv_seen - fv0); end
    endtask

    task automatic test_reset_mid;
        int fv0, ab0;
        fv0 = fv_seen; ab0 = ab_seen;
        for (int i = 0; i < 5; i++) send_bit(i[0], i == 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_ec = 0;
        idle(1);
        checks++; if (fv_seen != fv0 || ab_seen != ab0) begin errors++; $display("FAIL rstmid_pulses got=fv%0d/ab%0d exp=fv%0d/ab%0d", fv_seen, ab_seen, fv0, ab0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr got=%b exp=0", parity_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rstmid_err_count got=%0d exp=0", err_count); end
        // Parity bit after reset must be ignored since the frame was dropped.
        send_bit(1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stray_fv got=%b exp=0", frame_valid); end
    endtask

    task automatic test_back_to_back;
        int fv0, missed;
        fv0 = fv_seen;
        missed = 0;
        for (int f = 0; f < 260; f++) begin
            send_data(8'hA5);
            send_bit(1'b1, 1'b0);
            bump_ec(1'b1);
            if (frame_valid !== 1'b1 || parity_err !== 1'b1) missed++;
            if (f == 254) begin
                checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL b2b_err_count_255 got=%0d exp=%0d", err_count, exp_ec); end
            end
        end
        checks++; if (missed != 0) begin errors++; $display("FAIL b2b_fv_each_frame got=%0d missed exp=0", missed); end
        idle(1);
        checks++; if (fv_seen - fv0 != 260) begin errors++; $display("FAIL b2b_fv_count got=%0d exp=260", fv_seen - fv0); end
        checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL b2b_err_count_sat got=%0d exp=%0d", err_count, exp_ec); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL fv_abort_overlap got=%0d exp=0", overlap); end
    endtask

    initial begin
        test_reset();
        test_even_ok();
        test_even_bad();
        test_odd();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
